// File: rtl/decode_issue.sv
// Decode/issue stage: splits an instruction word into ALU op, operands and destination,
// resolving operands from the register file or the writeback bypass, behind a one-entry output register.
module decode_issue #(
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [3:0]  rf_ra_addr,
    output logic [3:0]  rf_rb_addr,
    input  logic [31:0] rf_ra_data,
    input  logic [31:0] rf_rb_data,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_rd,
    output logic        illegal,
    output logic [15:0] issue_count
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_LSL  = 4'd5,
        OP_LSR  = 4'd6,
        OP_ASR  = 4'd7,
        OP_MVT  = 4'd8,
        OP_SEQ  = 4'd9,
        OP_SLT  = 4'd10,
        OP_SLTE = 4'd11
    } op_e;

    logic        imm_sel;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] imm16;
    logic        legal;
    logic        accept;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;

    // rb and imm16 overlap in bit 15; imm selects which interpretation is used.
    assign imm_sel = in_instr[31];
    assign op      = in_instr[30:27];
    assign rd      = in_instr[26:23];
    assign ra      = in_instr[22:19];
    assign rb      = in_instr[18:15];
    assign imm16   = in_instr[15:0];

    assign rf_ra_addr = ra;
    assign rf_rb_addr = rb;

    assign legal    = (op <= OP_SLTE);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    function automatic logic [31:0] read_operand(
        input logic [3:0]  addr,
        input logic [31:0] rf_data,
        input logic        byp_valid,
        input logic [3:0]  byp_rd,
        input logic [31:0] byp_data
    );
        logic [31:0] value;
        value = rf_data;
        if (ZERO_R0 && (addr == 4'd0)) begin
            value = 32'h0;
        end else if (byp_valid && (byp_rd == addr)) begin
            value = byp_data;
        end
        return value;
    endfunction

    always_comb begin
        opnd_a = read_operand(ra, rf_ra_data, wb_valid, wb_rd, wb_data);
        if (imm_sel) begin
            opnd_b = {{16{imm16[15]}}, imm16};
        end else begin
            opnd_b = read_operand(rb, rf_rb_data, wb_valid, wb_rd, wb_data);
        end
    end

    // Operands are captured only on acceptance, so a stalled entry never sees later bypass traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_op      <= 4'd0;
            out_a       <= 32'h0;
            out_b       <= 32'h0;
            out_rd      <= 4'd0;
            illegal     <= 1'b0;
            issue_count <= 16'd0;
        end else begin
            illegal <= accept && !legal;
            if (out_valid && out_ready) begin
                issue_count <= issue_count + 16'd1;
            end
            if (accept && legal) begin
                out_valid <= 1'b1;
                out_op    <= op;
                out_a     <= opnd_a;
                out_b     <= opnd_b;
                out_rd    <= rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
